// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared constants and types for the RV32I integer ALU slice.
//   XLEN_DEFAULT   : default operand/result width
//   OP_IMM, OP     : RV32I major opcodes handled by the ALU
//   funct3_e       : funct3 encodings of the integer register/immediate group
//   shift_mode_e   : barrel shifter operating modes
//   bit_reverse32  : helper used to build a left shift from a right shifter
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP     = 7'b0110011;

  typedef enum logic [2:0] {
    F3_ADD  = 3'b000,
    F3_SLL  = 3'b001,
    F3_SLT  = 3'b010,
    F3_SLTU = 3'b011,
    F3_XOR  = 3'b100,
    F3_SR   = 3'b101,
    F3_OR   = 3'b110,
    F3_AND  = 3'b111
  } funct3_e;

  typedef enum logic [1:0] {
    SHIFT_SLL = 2'b00,
    SHIFT_SRL = 2'b01,
    SHIFT_SRA = 2'b10
  } shift_mode_e;

  function automatic logic [31:0] bit_reverse32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_if.sv
// -----------------------------------------------------------------------------
// alu_if
// Instruction/operand bus into the ALU and registered result back out.
//   opcode  : RV32I major opcode
//   funct3  : RV32I funct3 field
//   modbit  : instruction bit 30 (SUB / SRA select)
//   imm     : sign-extended I-type immediate
//   rs1/rs2 : source operands
//   rd      : registered result
//   comp    : registered completion flag for rd
// Modports: master drives the instruction side, slave is the ALU.
// -----------------------------------------------------------------------------
interface alu_if #(
  parameter int XLEN = alu_pkg::XLEN_DEFAULT
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            modbit;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic [XLEN-1:0] rd;
  logic            comp;

  modport master (
    output opcode,
    output funct3,
    output modbit,
    output imm,
    output rs1,
    output rs2,
    input  rd,
    input  comp
  );

  modport slave (
    input  opcode,
    input  funct3,
    input  modbit,
    input  imm,
    input  rs1,
    input  rs2,
    output rd,
    output comp
  );

endinterface

// File: rtl/alu_shifter.sv
// -----------------------------------------------------------------------------
// alu_shifter
// 32-bit five-stage logarithmic barrel shifter.
//   a     : value to shift
//   shamt : shift amount (0..31)
//   mode  : SHIFT_SLL, SHIFT_SRL or SHIFT_SRA
//   y     : shifted result
// Only a right shifter is built; left shifts reverse the bit order on the
// way in and out, so one set of stage muxes serves all three modes.
// -----------------------------------------------------------------------------
module alu_shifter
  import alu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [4:0]  shamt,
  input  shift_mode_e mode,
  output logic [31:0] y
);

  logic        fill;
  logic [31:0] stage [0:5];

  // Only an arithmetic right shift fills with the sign bit.
  assign fill     = (mode == SHIFT_SRA) ? a[31] : 1'b0;
  assign stage[0] = (mode == SHIFT_SLL) ? bit_reverse32(a) : a;

  for (genvar g = 0; g < 5; g++) begin : g_stage
    localparam int DIST = 1 << g;
    assign stage[g+1] = shamt[g] ? {{DIST{fill}}, stage[g][31:DIST]} : stage[g];
  end

  assign y = (mode == SHIFT_SLL) ? bit_reverse32(stage[5]) : stage[5];

endmodule

// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu
// RV32I integer ALU with a single registered result stage.
//   clk   : sole clock, rising edge
//   reset : asynchronous, active-high; clears rd and comp immediately
//   bus   : alu_if slave modport (instruction/operands in, rd/comp out)
// Inputs are sampled every rising edge. A valid OP/OP-IMM opcode loads rd
// and raises comp; any other opcode holds rd and drops comp, so comp always
// describes the most recent edge only.
// -----------------------------------------------------------------------------
module alu
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  alu_if.slave bus
);

  logic            is_op;
  logic            is_op_imm;
  logic            valid;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] result;
  logic [XLEN-1:0] shift_y;
  shift_mode_e     shift_mode;
  funct3_e         f3;
  logic [XLEN-1:0] rd_q;
  logic            comp_q;

  assign is_op     = (bus.opcode == OP);
  assign is_op_imm = (bus.opcode == OP_IMM);
  assign valid     = is_op | is_op_imm;

  assign op_a = bus.rs1;
  assign op_b = is_op_imm ? bus.imm : bus.rs2;
  assign f3   = funct3_e'(bus.funct3);

  always_comb begin
    shift_mode = SHIFT_SLL;
    if (f3 == F3_SR) begin
      shift_mode = bus.modbit ? SHIFT_SRA : SHIFT_SRL;
    end
  end

  // For immediates, bit 30 belongs to the immediate itself (SRAI aside), so
  // modbit only selects subtraction for register-register ops.
  alu_shifter u_shifter (
    .a     (op_a),
    .shamt (op_b[4:0]),
    .mode  (shift_mode),
    .y     (shift_y)
  );

  always_comb begin
    result = '0;
    unique case (f3)
      F3_ADD:  result = (is_op && bus.modbit) ? (op_a - op_b) : (op_a + op_b);
      F3_SLL:  result = shift_y;
      F3_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      F3_SLTU: result = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      F3_XOR:  result = op_a ^ op_b;
      F3_SR:   result = shift_y;
      F3_OR:   result = op_a | op_b;
      F3_AND:  result = op_a & op_b;
      default: result = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q   <= '0;
      comp_q <= 1'b0;
    end else begin
      comp_q <= valid;
      if (valid) begin
        rd_q <= result;
      end
    end
  end

  assign bus.rd   = rd_q;
  assign bus.comp = comp_q;

endmodule

// File: tb/tb_alu.sv
// -----------------------------------------------------------------------------
// tb_alu
// Directed vector bench for the alu: a table of instructions with
// hand-computed results applied back to back, plus sequences for reset.
// -----------------------------------------------------------------------------
module tb_alu;
  import alu_pkg::*;

  typedef struct {
    string       name;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        modbit;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] exp_rd;
    logic        exp_comp;
  } vec_t;

  logic clk;
  logic reset;
  int   pass_cnt;
  int   total_cnt;

  alu_if #(.XLEN(32)) bus ();

  alu #(.XLEN(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act_rd, input logic act_comp,
                       input logic [31:0] exp_rd, input logic exp_comp);
    total_cnt++;
    if (act_rd === exp_rd && act_comp === exp_comp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: rd=%08h comp=%0b, expected rd=%08h comp=%0b",
               name, act_rd, act_comp, exp_rd, exp_comp);
    end
  endtask

  task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic mb,
                       input logic [31:0] imm, input logic [31:0] a, input logic [31:0] b);
    bus.opcode = opc;
    bus.funct3 = f3;
    bus.modbit = mb;
    bus.imm    = imm;
    bus.rs1    = a;
    bus.rs2    = b;
  endtask

  vec_t vecs [$];

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    reset     = 1'b0;
    drive(7'b0, 3'b0, 1'b0, 32'h0, 32'h0, 32'h0);

    vecs.push_back('{"add",        OP,     3'b000, 1'b0, 32'h0,        32'h5,        32'h7,        32'h0000000C, 1'b1});
    vecs.push_back('{"sub",        OP,     3'b000, 1'b1, 32'h0,        32'h5,        32'h7,        32'hFFFFFFFE, 1'b1});
    vecs.push_back('{"addi_mb1",   OP_IMM, 3'b000, 1'b1, 32'hFFFFFFFF, 32'h10,       32'h0,        32'h0000000F, 1'b1});
    vecs.push_back('{"srl",        OP,     3'b101, 1'b0, 32'h0,        32'h80000000, 32'h24,       32'h08000000, 1'b1});
    vecs.push_back('{"sra",        OP,     3'b101, 1'b1, 32'h0,        32'h80000000, 32'h24,       32'hF8000000, 1'b1});
    vecs.push_back('{"slt",        OP,     3'b010, 1'b0, 32'h0,        32'hFFFFFFFF, 32'h1,        32'h00000001, 1'b1});
    vecs.push_back('{"sltu",       OP,     3'b011, 1'b0, 32'h0,        32'hFFFFFFFF, 32'h1,        32'h00000000, 1'b1});
    vecs.push_back('{"addi_55",    OP_IMM, 3'b000, 1'b0, 32'h5,        32'h50,       32'h0,        32'h00000055, 1'b1});
    vecs.push_back('{"branch_hold",7'b1100011, 3'b000, 1'b0, 32'h0,    32'h1,        32'h2,        32'h00000055, 1'b0});
    vecs.push_back('{"sll31",      OP,     3'b001, 1'b0, 32'h0,        32'h00000001, 32'h1F,       32'h80000000, 1'b1});
    vecs.push_back('{"sll_sh0",    OP,     3'b001, 1'b0, 32'h0,        32'hDEADBEEF, 32'h20,       32'hDEADBEEF, 1'b1});
    vecs.push_back('{"sra_sh0",    OP,     3'b101, 1'b1, 32'h0,        32'h80000001, 32'h40,       32'h80000001, 1'b1});
    vecs.push_back('{"xor",        OP,     3'b100, 1'b0, 32'h0,        32'h0000F0F0, 32'h0000FF00, 32'h00000FF0, 1'b1});
    vecs.push_back('{"or",         OP,     3'b110, 1'b0, 32'h0,        32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 1'b1});
    vecs.push_back('{"andi",       OP_IMM, 3'b111, 1'b0, 32'h0000FF00, 32'h0000F0F0, 32'h0,        32'h0000F000, 1'b1});
    vecs.push_back('{"add_wrap",   OP,     3'b000, 1'b0, 32'h0,        32'hFFFFFFFF, 32'h2,        32'h00000001, 1'b1});
    vecs.push_back('{"sub_wrap",   OP,     3'b000, 1'b1, 32'h0,        32'h0,        32'h1,        32'hFFFFFFFF, 1'b1});
    vecs.push_back('{"slti",       OP_IMM, 3'b010, 1'b0, 32'h3,        32'hFFFFFFFB, 32'h0,        32'h00000001, 1'b1});
    vecs.push_back('{"sltiu",      OP_IMM, 3'b011, 1'b0, 32'h3,        32'hFFFFFFFB, 32'h0,        32'h00000000, 1'b1});
    vecs.push_back('{"srai31",     OP_IMM, 3'b101, 1'b1, 32'h0000041F, 32'h80000000, 32'h0,        32'hFFFFFFFF, 1'b1});
    vecs.push_back('{"load_hold",  7'b0000011, 3'b000, 1'b0, 32'h0,    32'h7,        32'h7,        32'hFFFFFFFF, 1'b0});
    vecs.push_back('{"srli",       OP_IMM, 3'b101, 1'b0, 32'h4,        32'h80000000, 32'h0,        32'h08000000, 1'b1});
    vecs.push_back('{"slli",       OP_IMM, 3'b001, 1'b0, 32'h8,        32'h000000AB, 32'h0,        32'h0000AB00, 1'b1});

    // Asynchronous reset with the clock well away from an edge.
    @(negedge clk);
    #1 reset = 1'b1;
    #1 check("reset_async", bus.rd, bus.comp, 32'h0, 1'b0);
    @(posedge clk);
    #1 check("reset_held", bus.rd, bus.comp, 32'h0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].opcode, vecs[i].funct3, vecs[i].modbit, vecs[i].imm, vecs[i].rs1, vecs[i].rs2);
      @(posedge clk);
      #1 check(vecs[i].name, bus.rd, bus.comp, vecs[i].exp_rd, vecs[i].exp_comp);
    end

    // Result 0x1234 then reset between edges, with a valid op pending.
    @(negedge clk);
    drive(OP, 3'b000, 1'b0, 32'h0, 32'h1200, 32'h34);
    @(posedge clk);
    #1 check("pre_reset_1234", bus.rd, bus.comp, 32'h1234, 1'b1);
    @(negedge clk);
    drive(OP, 3'b110, 1'b0, 32'h0, 32'hAAAA0000, 32'h5555);
    #1 reset = 1'b1;
    #1 check("mid_reset_clear", bus.rd, bus.comp, 32'h0, 1'b0);
    @(posedge clk);
    #1 check("reset_discard", bus.rd, bus.comp, 32'h0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    drive(OP, 3'b111, 1'b0, 32'h0, 32'hF0F0, 32'hFF00);
    @(posedge clk);
    #1 check("post_reset_and", bus.rd, bus.comp, 32'h0000F000, 1'b1);

    // Invalid opcode after reset release keeps rd and drops comp.
    @(negedge clk);
    drive(7'b1111111, 3'b000, 1'b0, 32'h0, 32'h1, 32'h1);
    @(posedge clk);
    #1 check("post_reset_hold", bus.rd, bus.comp, 32'h0000F000, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected finish before 100000");
    $fatal(1);
  end

endmodule
